// File: rtl/axis_uart_tx_pkg.sv
// Shared UART definitions: state encoding and default bit period.
// Intended for reuse by the companion UART receiver.
package axis_uart_tx_pkg;

    localparam int unsigned UART_DEFAULT_DIVISOR = 104;
    localparam int unsigned UART_DATA_BITS       = 8;
    localparam int unsigned UART_BIDX_W          = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

endpackage

// File: rtl/axis_uart_tx_if.sv
// Byte stream handshake between the upstream register stage and the UART transmitter.
interface axis_uart_tx_if;
    import axis_uart_tx_pkg::*;

    uart_byte_t idata;
    logic       ivalid;
    logic       iready;

    modport master (output idata, output ivalid, input iready);
    modport slave  (input idata, input ivalid, output iready);

endinterface

// File: rtl/axis_uart_tx_baud_counter.sv
// Bit-period counter: counts 0..DIVISOR-1 while enabled, tick flags the terminal count.
module axis_uart_tx_baud_counter #(
    parameter int unsigned DIVISOR = 104,
    parameter int unsigned CWIDTH  = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [CWIDTH-1:0] TERMINAL = CWIDTH'(DIVISOR - 1);

    logic [CWIDTH-1:0] count;

    assign tick = enable && (count == TERMINAL);

    // Clear has priority so a new frame always starts on a full bit period.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + CWIDTH'(1);
        end
    end

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-stream byte sink that serializes each accepted byte as a UART 8N1 frame on txd.
module axis_uart_tx
    import axis_uart_tx_pkg::*;
#(
    parameter int unsigned DIVISOR = UART_DEFAULT_DIVISOR,
    parameter int unsigned CWIDTH  = 16
) (
    input  logic           clock,
    input  logic           resetn,
    axis_uart_tx_if.slave  up,
    output logic           txd,
    output logic           busy
);

    uart_state_e            state, state_n;
    uart_byte_t             shift, shift_n;
    logic [UART_BIDX_W-1:0] bidx, bidx_n;
    logic                   txd_n;
    logic                   iready, iready_n;
    logic                   busy_n;
    logic                   transfer_c;
    logic                   tick;

    assign up.iready  = iready;
    assign transfer_c = up.ivalid && iready;

    axis_uart_tx_baud_counter #(
        .DIVISOR (DIVISOR),
        .CWIDTH  (CWIDTH)
    ) u_baud (
        .clock  (clock),
        .resetn (resetn),
        .clear  (transfer_c),
        .enable (state != IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            shift  <= '0;
            bidx   <= '0;
            txd    <= 1'b1;
            iready <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            shift  <= shift_n;
            bidx   <= bidx_n;
            txd    <= txd_n;
            iready <= iready_n;
            busy   <= busy_n;
        end
    end

    // txd is computed one cycle ahead so the registered pin changes exactly on bit boundaries.
    always_comb begin
        state_n = state;
        shift_n = shift;
        bidx_n  = bidx;
        txd_n   = txd;
        unique case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (transfer_c) begin
                    state_n = START;
                    shift_n = up.idata;
                    txd_n   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    bidx_n  = '0;
                    txd_n   = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = {1'b0, shift[UART_DATA_BITS-1:1]};
                    if (bidx == UART_BIDX_W'(UART_DATA_BITS - 1)) begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bidx_n = bidx + UART_BIDX_W'(1);
                        txd_n  = shift[1];
                    end
                end
            end
            STOP: begin
                txd_n = 1'b1;
                if (tick) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
            end
        endcase
        iready_n = (state_n == IDLE);
        busy_n   = (state_n != IDLE);
    end

endmodule
